// File: rtl/sr_pkg.sv
// Shared definitions for the SR latch pulse driver: FSM encoding and default timing.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        RST_P = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_PULSE_CYCLES    = 4;

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-FF synchronizer, run-length debouncer and a one-cycle
// request on each rising edge of the debounced level.
module btn_debounce
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic req
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          deb_reg;
    logic          req_reg;
    logic [CW-1:0] cnt_reg;
    logic          differ;
    logic          flip;

    assign differ = (sync2_reg != deb_reg);
    // Flipping on the edge that would make the count reach DEBOUNCE_CYCLES keeps the counter from ever holding it.
    assign flip   = differ && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            deb_reg   <= 1'b0;
            req_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            if (!differ || flip) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (flip) begin
                deb_reg <= ~deb_reg;
            end
            req_reg <= flip && !deb_reg;
        end
    end

    assign req = req_reg;

endmodule

// File: rtl/sr_pulse_gen.sv
// Debounced set/reset buttons to mutually exclusive active-low pulses for an SR latch;
// simultaneous requests are dropped and reported on conflict.
module sr_pulse_gen
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_reset,
    output logic S_n,
    output logic R_n,
    output logic busy,
    output logic conflict
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

    logic [1:0]    btn_vec;
    logic [1:0]    req_vec;
    state_t        state_reg;
    state_t        state_next;
    logic [PW-1:0] pcnt_reg;
    logic [PW-1:0] pcnt_next;
    logic          set_pend_reg;
    logic          set_pend_next;
    logic          rst_pend_reg;
    logic          rst_pend_next;
    logic          set_clr;
    logic          rst_clr;
    logic          conflict_next;
    logic          s_n_reg;
    logic          r_n_reg;
    logic          conflict_reg;

    assign btn_vec = {btn_reset, btn_set};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk  (clk),
                .rst_n(rst_n),
                .btn  (btn_vec[gi]),
                .req  (req_vec[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        pcnt_next     = pcnt_reg;
        set_clr       = 1'b0;
        rst_clr       = 1'b0;
        conflict_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (set_pend_reg && rst_pend_reg) begin
                    set_clr       = 1'b1;
                    rst_clr       = 1'b1;
                    conflict_next = 1'b1;
                end else if (set_pend_reg) begin
                    state_next = SET_P;
                    set_clr    = 1'b1;
                end else if (rst_pend_reg) begin
                    state_next = RST_P;
                    rst_clr    = 1'b1;
                end
            end
            SET_P, RST_P: begin
                if (pcnt_reg == PULSE_LAST) begin
                    state_next = GAP;
                    pcnt_next  = '0;
                end else begin
                    pcnt_next = pcnt_reg + 1'b1;
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A request landing on the clearing cycle is a fresh press and must survive.
        set_pend_next = req_vec[0] | (set_pend_reg & ~set_clr);
        rst_pend_next = req_vec[1] | (rst_pend_reg & ~rst_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            pcnt_reg     <= '0;
            set_pend_reg <= 1'b0;
            rst_pend_reg <= 1'b0;
            s_n_reg      <= 1'b1;
            r_n_reg      <= 1'b1;
            conflict_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pcnt_reg     <= pcnt_next;
            set_pend_reg <= set_pend_next;
            rst_pend_reg <= rst_pend_next;
            s_n_reg      <= (state_next != SET_P);
            r_n_reg      <= (state_next != RST_P);
            conflict_reg <= conflict_next;
        end
    end

    assign S_n      = s_n_reg;
    assign R_n      = r_n_reg;
    assign busy     = (state_reg != IDLE);
    assign conflict = conflict_reg;

endmodule

// File: doc/sr_pulse_gen.md
# sr_pulse_gen

Upstream driver for the board-level active-low SR latch. Takes two raw pushbuttons (set, reset), synchronizes and debounces each, and turns each debounced press into a single fixed-width active-low pulse on S_n or R_n. It guarantees the latch never sees S_n and R_n low together. Simultaneous set and reset requests are dropped and flagged instead.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronized input must differ from its debounced value before that value flips (≥2).
- PULSE_CYCLES, 4: low width of each S_n/R_n pulse, in clocks (≥1).
- clk  input  1  system clock; all state is updated on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_set  input  1  raw set button, active-high, asynchronous to clk.
- btn_reset  input  1  raw reset button, active-high, asynchronous to clk.
- S_n  output  1  set pulse to the latch, active-low, registered.
- R_n  output  1  reset pulse to the latch, active-low, registered.
- busy  output  1  high while a pulse or guard gap is in progress.
- conflict  output  1  one-cycle pulse when set and reset requests collide.

## Operation
- Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debouncer's counter increments while the synchronized value differs from the debounced value, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced value flips and the counter clears.
- A rising edge of a debounced value raises that channel's request for one cycle. Releases generate nothing.
- Each channel has a one-deep pending flag.
  - A request sets the flag.
  - The flag clears when its pulse starts, or on conflict.
  - A second request while the flag is set is absorbed.
- FSM states: IDLE, SET_P, RST_P, GAP.
  - IDLE, both pending: clear both flags, pulse conflict, stay in IDLE.
  - IDLE, only set pending: go to SET_P, clear set_pend.
  - IDLE, only reset pending: go to RST_P, clear rst_pend.
  - SET_P / RST_P: S_n (resp. R_n) is low for exactly PULSE_CYCLES cycles, then go to GAP.
  - GAP: one cycle with both outputs high, then go to IDLE.
- Requests arriving during SET_P, RST_P or GAP are held pending and serviced from IDLE under the same rules.
- busy = (state != IDLE).
- Invariant: S_n and R_n are never both 0.
- Counter width is $clog2(DEBOUNCE_CYCLES+1). The pulse counter is $clog2(PULSE_CYCLES+1). Neither counter wraps.

## Timing
- Reset values:
  - Outputs: S_n=1, R_n=1, busy=0, conflict=0.
  - Internal state: synchronizers 0, debounced values 0, counters 0, pending flags 0, state IDLE.
- Reset asserted mid-pulse forces S_n/R_n high immediately (asynchronously). Nothing resumes after reset is released.
- Latency, for a clean press first sampled at edge k:
  - Debounced value rises at edge k+1+DEBOUNCE_CYCLES.
  - The request is seen in IDLE, and S_n falls at edge k+3+DEBOUNCE_CYCLES.
  - S_n rises PULSE_CYCLES edges later.
  - busy falls one cycle after that (GAP).
- Back-to-back service: the minimum period between the starts of two pulses is PULSE_CYCLES+2 cycles.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no request and no output change.
- conflict is registered and high for exactly one cycle.

## Structure
- Shared package sr_pkg holds:
  - FSM state encoding (IDLE=2'd0, SET_P=2'd1, RST_P=2'd2, GAP=2'd3).
  - Default DEBOUNCE_CYCLES and PULSE_CYCLES constants.
- One sub-module, btn_debounce: synchronizer, debounce counter and rising-edge request for a single button. It is instantiated twice.
- The top level holds the pending flags, FSM, pulse counter and output registers.

## Test plan
- Reset behaviour: hold rst_n=0 with buttons toggling -> S_n=R_n=1, busy=0 throughout. Release reset -> no pulse.
- Clean set press: btn_set held high for 40 cycles (defaults) -> S_n low for exactly 4 cycles, starting 19 edges after first sample. R_n stays 1. busy is high for 5 cycles.
- Bounce rejection: btn_set toggled every 5 cycles for 60 cycles, then held high -> exactly one S_n pulse, timed from the final stable edge.
- Simultaneous press: btn_set and btn_reset rise on the same edge -> one-cycle conflict. No S_n or R_n pulse.
- Queued request: btn_reset debounces during an S_n pulse -> the S_n pulse completes, then a 1-cycle gap with both outputs high, then R_n is low for 4 cycles.
- Reset mid-pulse: rst_n pulled low in the 2nd cycle of S_n low -> S_n=1 immediately. After release, state is IDLE with no pending pulse.
